// File: rtl/conv_window_ctrl_pkg.sv
// Shared definitions for the conv-stage stream controllers.
// Holds the controller state encoding and elaboration-time width helpers.
// Pure declarations: no logic, no latency, no backpressure.
package conv_window_ctrl_pkg;

  // Controller state encoding; 3 bits leaves room for future stages.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // waiting for pixel (0,0)
    ST_PRIME = 3'd1,  // filling K-1 rows plus K-1 pixels of the line buffer
    ST_CALC  = 3'd2,  // window-producing columns of a row
    ST_WRAP  = 3'd3,  // first K-1 columns of a row, no windows
    ST_DONE  = 3'd4   // one-cycle end-of-frame bubble
  } state_t;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Stride phase counter width; a unit stride still needs a 1-bit vector.
  function automatic int phase_width(input int stride);
    return (stride > 1) ? clog2(stride) : 1;
  endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream and window-output bundle between the pixel source/conv datapath and the controller.
// Wiring only: no latency.
// TREADY is the only backpressure towards the source; M_READY carries the conv engine's readiness.
interface conv_window_ctrl_if #(
  parameter int CW = 5
) ();

  logic          S_AXIS_TVALID;
  logic          S_AXIS_TLAST;
  logic          S_AXIS_TREADY;
  logic          M_READY;
  logic          Buf_Wr_En;
  logic          Cal_Valid;
  logic [CW-1:0] Win_Col;
  logic [CW-1:0] Win_Row;
  logic          Frame_Done;
  logic          Err_Last;

  // Environment side: pixel source and conv engine.
  modport master (
    output S_AXIS_TVALID, S_AXIS_TLAST, M_READY,
    input  S_AXIS_TREADY, Buf_Wr_En, Cal_Valid, Win_Col, Win_Row, Frame_Done, Err_Last
  );

  // Controller side.
  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TLAST, M_READY,
    output S_AXIS_TREADY, Buf_Wr_En, Cal_Valid, Win_Col, Win_Row, Frame_Done, Err_Last
  );

endinterface

// File: rtl/conv_window_ctrl_win_pos_counter.sv
// Raster position counters (col/row) plus mod-STRIDE phase counters anchored at col/row K-1.
// Latency: outputs describe the pixel the next beat will consume; they advance 1 cycle after adv_i.
// Backpressure: holds every count while adv_i is low.
module conv_window_ctrl_win_pos_counter
  import conv_window_ctrl_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int CW     = 5,
  parameter int PW     = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [CW-1:0] row_o,
  output logic [PW-1:0] col_ph_o,
  output logic [PW-1:0] row_ph_o,
  output logic          col_last_o,
  output logic          row_last_o
);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ANCHOR  = CW'(K - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(STRIDE - 1);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [PW-1:0] col_ph_q, col_ph_d;
  logic [PW-1:0] row_ph_q, row_ph_d;

  // The phase restarts at the first window-capable coordinate and then cycles
  // 0..STRIDE-1, so "phase == 0" marks stride-aligned positions without a divider.
  // Before the anchor the phase value is irrelevant.
  function automatic logic [PW-1:0] next_phase(input logic [CW-1:0] nxt_pos,
                                               input logic [PW-1:0] cur_ph);
    logic [PW-1:0] ph;
    if (nxt_pos == ANCHOR) begin
      ph = '0;
    end else if (cur_ph == PH_MAX) begin
      ph = '0;
    end else begin
      ph = cur_ph + 1'b1;
    end
    return ph;
  endfunction

  assign col_last_o = (col_q == COL_MAX);
  assign row_last_o = (row_q == ROW_MAX);
  assign col_o      = col_q;
  assign row_o      = row_q;
  assign col_ph_o   = col_ph_q;
  assign row_ph_o   = row_ph_q;

  // Next position: step the column, wrap into the next row, wrap the frame to (0,0).
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (adv_i) begin
      if (col_last_o) begin
        col_d    = '0;
        col_ph_d = '0;
        row_d    = row_last_o ? '0 : row_q + 1'b1;
        row_ph_d = next_phase(row_d, row_ph_q);
      end else begin
        col_d    = col_q + 1'b1;
        col_ph_d = next_phase(col_d, col_ph_q);
      end
    end
  end

  // Position and phase registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q    <= '0;
      row_q    <= '0;
      col_ph_q <= '0;
      row_ph_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sliding-window controller: counts accepted pixels, strobes line-buffer writes and window-valid with coordinates.
// Latency: Buf_Wr_En combinational with the beat; Cal_Valid/Win_*/Frame_Done/Err_Last registered, 1 cycle after the beat.
// Backpressure: TREADY = M_READY and not in the end-of-frame bubble; everything freezes while no beat occurs.
module conv_window_ctrl
  import conv_window_ctrl_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int CW     = 5
) (
  input  logic          S_AXIS_ACLK,
  input  logic          S_AXIS_ARESETN,
  conv_window_ctrl_if.slave s_axis
);

  localparam int PW = phase_width(STRIDE);

  localparam logic [CW-1:0] ANCHOR    = CW'(K - 1);
  localparam logic [CW-1:0] PRIME_COL = CW'(K - 2);

  // Reject geometries the counters and state machine cannot represent.
  if (K < 2 || IMG_W < K || IMG_H < K || STRIDE < 1 || STRIDE > K ||
      IMG_W > (1 << CW) || IMG_H > (1 << CW)) begin : g_bad_geometry
    $error("conv_window_ctrl: illegal IMG_W/IMG_H/K/STRIDE/CW combination");
  end

  state_t        state_q;
  logic          cal_valid_q;
  logic [CW-1:0] win_col_q;
  logic [CW-1:0] win_row_q;
  logic          frame_done_q;
  logic          err_last_q;

  logic          tready;
  logic          beat;
  logic          win_hit;
  logic          last_mismatch;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [PW-1:0] col_ph;
  logic [PW-1:0] row_ph;
  logic          col_last;
  logic          row_last;

  // The DONE bubble is the only cycle the controller itself refuses pixels.
  assign tready = s_axis.M_READY && (state_q != ST_DONE);
  assign beat   = s_axis.S_AXIS_TVALID && tready;

  // A window is complete when its bottom-right pixel lands on a stride-aligned position.
  assign win_hit = beat && (state_q == ST_CALC) && (row >= ANCHOR) && (col >= ANCHOR) &&
                   (col_ph == '0) && (row_ph == '0);

  // Internal geometry is authoritative; TLAST is only cross-checked.
  assign last_mismatch = beat && (s_axis.S_AXIS_TLAST != col_last);

  assign s_axis.S_AXIS_TREADY = tready;
  assign s_axis.Buf_Wr_En     = beat;
  assign s_axis.Cal_Valid     = cal_valid_q;
  assign s_axis.Win_Col       = win_col_q;
  assign s_axis.Win_Row       = win_row_q;
  assign s_axis.Frame_Done    = frame_done_q;
  assign s_axis.Err_Last      = err_last_q;

  conv_window_ctrl_win_pos_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .STRIDE (STRIDE),
    .CW     (CW),
    .PW     (PW)
  ) u_pos (
    .clk_i      (S_AXIS_ACLK),
    .rst_ni     (S_AXIS_ARESETN),
    .adv_i      (beat),
    .col_o      (col),
    .row_o      (row),
    .col_ph_o   (col_ph),
    .row_ph_o   (row_ph),
    .col_last_o (col_last),
    .row_last_o (row_last)
  );

  // Frame state machine with registered window, frame-done and TLAST-error outputs.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q      <= ST_IDLE;
      cal_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_done_q <= 1'b0;
      err_last_q   <= 1'b0;
    end else begin
      cal_valid_q  <= win_hit;
      frame_done_q <= 1'b0;
      if (win_hit) begin
        win_col_q <= col - ANCHOR;
        win_row_q <= row - ANCHOR;
      end
      if (last_mismatch) begin
        err_last_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (beat) begin
            state_q <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (beat && (row == ANCHOR) && (col == PRIME_COL)) begin
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (beat && col_last) begin
            if (row_last) begin
              state_q      <= ST_DONE;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= ST_WRAP;
            end
          end
        end
        ST_WRAP: begin
          if (beat && (col == PRIME_COL)) begin
            state_q <= ST_CALC;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench: two controllers (stride 1 and stride 2) share one random pixel stream.
// The driver predicts windows/frame-done from raster geometry; monitors pop and compare on DUT strobes.
module tb_conv_window_ctrl;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int K  = 3;
  localparam int CW = 3;
  localparam int WIN_S1 = ((W - K) / 1 + 1) * ((H - K) / 1 + 1);
  localparam int WIN_S2 = ((W - K) / 2 + 1) * ((H - K) / 2 + 1);

  typedef struct {
    int col;
    int row;
    int cyc;
  } win_t;

  logic clk = 1'b0;
  logic rst_n;
  logic tvalid;
  logic tlast;
  logic mready;

  always #5 clk = ~clk;

  conv_window_ctrl_if #(.CW(CW)) if_s1 ();
  conv_window_ctrl_if #(.CW(CW)) if_s2 ();

  assign if_s1.S_AXIS_TVALID = tvalid;
  assign if_s1.S_AXIS_TLAST  = tlast;
  assign if_s1.M_READY       = mready;
  assign if_s2.S_AXIS_TVALID = tvalid;
  assign if_s2.S_AXIS_TLAST  = tlast;
  assign if_s2.M_READY       = mready;

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1), .CW(CW)) dut_s1 (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .s_axis         (if_s1)
  );

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2), .CW(CW)) dut_s2 (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .s_axis         (if_s2)
  );

  logic          cv[2];
  logic          fd[2];
  logic          el[2];
  logic          trdy[2];
  logic          bwe[2];
  logic [CW-1:0] wc[2];
  logic [CW-1:0] wr[2];

  assign cv[0]   = if_s1.Cal_Valid;
  assign cv[1]   = if_s2.Cal_Valid;
  assign fd[0]   = if_s1.Frame_Done;
  assign fd[1]   = if_s2.Frame_Done;
  assign el[0]   = if_s1.Err_Last;
  assign el[1]   = if_s2.Err_Last;
  assign trdy[0] = if_s1.S_AXIS_TREADY;
  assign trdy[1] = if_s2.S_AXIS_TREADY;
  assign bwe[0]  = if_s1.Buf_Wr_En;
  assign bwe[1]  = if_s2.Buf_Wr_En;
  assign wc[0]   = if_s1.Win_Col;
  assign wc[1]   = if_s2.Win_Col;
  assign wr[0]   = if_s1.Win_Row;
  assign wr[1]   = if_s2.Win_Row;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   mcol   = 0;
  int   mrow   = 0;
  bit   bubble  = 1'b0;
  bit   exp_err = 1'b0;
  win_t wq0[$];
  win_t wq1[$];
  int   fdq0[$];
  int   fdq1[$];
  int   win_seen[2] = '{0, 0};
  int   fd_seen[2]  = '{0, 0};
  int   base_w[2];
  int   base_f[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rule: window anchored at (r-(K-1), c-(K-1)) exists when it fits and is stride-aligned.
  function automatic bit is_win(input int r, input int c, input int s);
    return (r >= K - 1) && (c >= K - 1) && ((r - (K - 1)) % s == 0) && ((c - (K - 1)) % s == 0);
  endfunction

  // One clock of stimulus: drive at posedge+1, check and predict at negedge.
  task automatic step(input bit tv, input bit mr, input bit flip, output bit beat);
    bit   nb;
    bit   pend;
    win_t e;
    tvalid = tv;
    mready = mr;
    tlast  = tv ? ((mcol == W - 1) ^ flip) : 1'b0;
    @(negedge clk);
    beat = tv && mr && !bubble;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("s%0d_tready", i + 1), int'(trdy[i]), int'(mr && !bubble));
      check($sformatf("s%0d_buf_wr_en", i + 1), int'(bwe[i]), int'(beat));
      check($sformatf("s%0d_err_last", i + 1), int'(el[i]), int'(exp_err));
    end
    nb   = 1'b0;
    pend = exp_err;
    if (beat) begin
      if (tlast != (mcol == W - 1)) pend = 1'b1;
      e.col = mcol - (K - 1);
      e.row = mrow - (K - 1);
      e.cyc = cyc + 1;
      if (is_win(mrow, mcol, 1)) wq0.push_back(e);
      if (is_win(mrow, mcol, 2)) wq1.push_back(e);
      if (mcol == W - 1 && mrow == H - 1) begin
        fdq0.push_back(cyc + 1);
        fdq1.push_back(cyc + 1);
        nb = 1'b1;
      end
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end
    @(posedge clk);
    #1;
    bubble  = nb;
    exp_err = pend;
  endtask

  // Push n pixels with random TVALID/M_READY, an optional M_READY stall and an optional TLAST flip.
  task automatic run_beats(input int n, input int vpct, input int mpct, input int stall_at,
                           input int stall_len, input int frow, input int fcol);
    int got;
    int sl;
    bit b;
    got = 0;
    sl  = stall_len;
    for (int c = 0; c < 4000 && got < n; c++) begin
      if (got == stall_at && sl > 0) begin
        step(1'b1, 1'b0, 1'b0, b);
        sl = sl - 1;
      end else begin
        step($urandom_range(99) < vpct, $urandom_range(99) < mpct,
             (mrow == frow && mcol == fcol), b);
      end
      if (b) got = got + 1;
    end
    check("beats_accepted", got, n);
  endtask

  task automatic phase_start();
    for (int i = 0; i < 2; i++) begin
      base_w[i] = win_seen[i];
      base_f[i] = fd_seen[i];
    end
  endtask

  task automatic phase_end(input string name, input int frames);
    bit b;
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0, b);
    check({name, "_s1_windows"}, win_seen[0] - base_w[0], frames * WIN_S1);
    check({name, "_s2_windows"}, win_seen[1] - base_w[1], frames * WIN_S2);
    check({name, "_s1_frame_done"}, fd_seen[0] - base_f[0], frames);
    check({name, "_s2_frame_done"}, fd_seen[1] - base_f[1], frames);
    check({name, "_pending_windows"}, wq0.size() + wq1.size(), 0);
    check({name, "_pending_frame_done"}, fdq0.size() + fdq1.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_s%0d_cal_valid", name, i + 1), int'(cv[i]), 0);
      check($sformatf("%s_s%0d_frame_done", name, i + 1), int'(fd[i]), 0);
      check($sformatf("%s_s%0d_err_last", name, i + 1), int'(el[i]), 0);
      check($sformatf("%s_s%0d_win_col", name, i + 1), int'(wc[i]), 0);
      check($sformatf("%s_s%0d_win_row", name, i + 1), int'(wr[i]), 0);
    end
  endtask

  // Asynchronous reset mid-frame: model forgets the partial frame and pending strobes.
  task automatic reset_mid();
    tvalid = 1'b0;
    rst_n  = 1'b0;
    wq0.delete();
    wq1.delete();
    fdq0.delete();
    fdq1.delete();
    mcol    = 0;
    mrow    = 0;
    bubble  = 1'b0;
    exp_err = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the scoreboard whenever a DUT strobe appears; flag entries that went overdue.
  always @(negedge clk) begin : mon
    win_t e;
    int   f;
    for (int i = 0; i < 2; i++) begin
      if (cv[i]) begin
        if ((i == 0 && wq0.size() == 0) || (i == 1 && wq1.size() == 0)) begin
          check($sformatf("s%0d_cal_valid_unexpected", i + 1), int'(cv[i]), 0);
        end else begin
          if (i == 0) e = wq0.pop_front();
          else        e = wq1.pop_front();
          check($sformatf("s%0d_win_col", i + 1), int'(wc[i]), e.col);
          check($sformatf("s%0d_win_row", i + 1), int'(wr[i]), e.row);
          check($sformatf("s%0d_cal_valid_cycle", i + 1), cyc, e.cyc);
          win_seen[i] = win_seen[i] + 1;
        end
      end
      if (i == 0 && wq0.size() > 0 && wq0[0].cyc < cyc) begin
        check("s1_cal_valid_missed", cyc, wq0[0].cyc);
        void'(wq0.pop_front());
      end
      if (i == 1 && wq1.size() > 0 && wq1[0].cyc < cyc) begin
        check("s2_cal_valid_missed", cyc, wq1[0].cyc);
        void'(wq1.pop_front());
      end
      if (fd[i]) begin
        if ((i == 0 && fdq0.size() == 0) || (i == 1 && fdq1.size() == 0)) begin
          check($sformatf("s%0d_frame_done_unexpected", i + 1), int'(fd[i]), 0);
        end else begin
          if (i == 0) f = fdq0.pop_front();
          else        f = fdq1.pop_front();
          check($sformatf("s%0d_frame_done_cycle", i + 1), cyc, f);
          fd_seen[i] = fd_seen[i] + 1;
        end
      end
      if (i == 0 && fdq0.size() > 0 && fdq0[0] < cyc) begin
        check("s1_frame_done_missed", cyc, fdq0[0]);
        void'(fdq0.pop_front());
      end
      if (i == 1 && fdq1.size() > 0 && fdq1[0] < cyc) begin
        check("s2_frame_done_missed", cyc, fdq1[0]);
        void'(fdq1.pop_front());
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    mready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_s1_tready", int'(trdy[0]), 1);
    check("reset_s2_tready", int'(trdy[1]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    phase_start();
    run_beats(36, 100, 100, -1, 0, -1, -1);
    phase_end("b2b", 1);

    phase_start();
    run_beats(36, 100, 100, 19, 3, -1, -1);
    phase_end("stall", 1);

    phase_start();
    run_beats(72, 70, 80, -1, 0, -1, -1);
    phase_end("random", 2);

    phase_start();
    run_beats(72, 100, 100, -1, 0, -1, -1);
    phase_end("two_frames", 2);

    run_beats(20, 100, 100, -1, 0, -1, -1);
    reset_mid();
    phase_start();
    run_beats(36, 100, 100, -1, 0, -1, -1);
    phase_end("after_reset", 1);

    phase_start();
    run_beats(36, 100, 100, -1, 0, 1, 3);
    phase_end("tlast_err", 1);
    check("tlast_err_s1_sticky", int'(el[0]), 1);
    check("tlast_err_s2_sticky", int'(el[1]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
